// File: rtl/key_mode_ctrl.sv
// Single/double click classifier driving an audio mode index (single = up, double = down).
// Define KEY_MODE_LED_EN to add the registered one-hot mode_led output.
module key_mode_ctrl #(
  parameter int                MODE_NUM   = 4,
  parameter int                MODE_W     = 2,
  parameter int                CNT_W      = 24,
  parameter logic [CNT_W-1:0]  DCLICK_WIN = 24'd5000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                key_on,
  input  logic                mode_lock,
  output logic                single_pulse,
  output logic                double_pulse,
  output logic [MODE_W-1:0]   mode,
  output logic                mode_chg
`ifdef KEY_MODE_LED_EN
  ,
  output logic [MODE_NUM-1:0] mode_led
`endif
);

  typedef enum logic {IDLE, WAIT2} state_t;

  localparam logic [CNT_W-1:0]  WIN_LAST = DCLICK_WIN - CNT_W'(1);
  localparam logic [MODE_W-1:0] MODE_MAX = MODE_W'(MODE_NUM - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                single_q, single_d;
  logic                double_q, double_d;
  logic [MODE_W-1:0]   mode_q, mode_d;
  logic                chg_q, chg_d;

  // Gesture FSM; a second press on the timeout edge still counts as a double.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    single_d = 1'b0;
    double_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_on) begin
          state_d = WAIT2;
          cnt_d   = '0;
        end
      end
      WAIT2: begin
        if (key_on) begin
          double_d = 1'b1;
          state_d  = IDLE;
        end else if (cnt_q == WIN_LAST) begin
          single_d = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // mode_lock only matters on the edge the gesture is classified.
  always_comb begin
    mode_d = mode_q;
    chg_d  = 1'b0;
    if (!mode_lock) begin
      if (single_d) begin
        mode_d = (mode_q == MODE_MAX) ? '0 : mode_q + MODE_W'(1);
        chg_d  = 1'b1;
      end else if (double_d) begin
        mode_d = (mode_q == '0) ? MODE_MAX : mode_q - MODE_W'(1);
        chg_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      single_q <= 1'b0;
      double_q <= 1'b0;
      mode_q   <= '0;
      chg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      single_q <= single_d;
      double_q <= double_d;
      mode_q   <= mode_d;
      chg_q    <= chg_d;
    end
  end

  assign single_pulse = single_q;
  assign double_pulse = double_q;
  assign mode         = mode_q;
  assign mode_chg     = chg_q;

`ifdef KEY_MODE_LED_EN
  logic [MODE_NUM-1:0] led_q, led_d;

  assign led_d = MODE_NUM'(1) << mode_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) led_q <= MODE_NUM'(1);
    else        led_q <= led_d;
  end

  assign mode_led = led_q;
`endif

endmodule
